// File: rtl/button_event_queue.sv
// Button poll responder: synchronise, debounce and queue button events for lw polls.
// Define BTN_EVENT_RELEASE_EN to also queue release events (read back with bit3 set).
module button_event_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               btn_in,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_EVENT_RELEASE_EN
  localparam int unsigned EW = 3;
`else
  localparam int unsigned EW = 2;
`endif
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2;
  logic [3:0]    db_level;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    db_accept;
  logic [3:0]    press_rise;
  logic [3:0]    press_pend;
  logic [3:0]    press_clr;

  logic          push;
  logic [1:0]    push_colour;
  logic [EW-1:0] wr_word;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          rd_en_q;
  logic          rd_rise;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic          overflow;
  logic          head_rel;
  logic [1:0]    head_colour;

`ifdef BTN_EVENT_RELEASE_EN
  logic [3:0]    release_fall;
  logic [3:0]    rel_pend;
  logic [3:0]    rel_clr;
  logic          push_rel;
`endif

  // Two-flop synchroniser ahead of all other button logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A level is accepted on the cycle its stability count would reach DEBOUNCE_CYCLES.
  always_comb begin
    db_accept = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      db_accept[i] = (sync2[i] != db_level[i]) && (db_cnt[i] == LAST_COUNT);
    end
  end

  assign press_rise = db_accept & sync2;
`ifdef BTN_EVENT_RELEASE_EN
  assign release_fall = db_accept & ~sync2;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_level <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_accept[i]) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index press wins; releases only go when no press is pending.
  always_comb begin
    push        = 1'b0;
    push_colour = '0;
    press_clr   = '0;
`ifdef BTN_EVENT_RELEASE_EN
    push_rel    = 1'b0;
    rel_clr     = '0;
`endif
    for (int unsigned i = 0; i < 4; i++) begin
      if (press_pend[i] && !push) begin
        push         = 1'b1;
        push_colour  = 2'(i);
        press_clr[i] = 1'b1;
      end
    end
`ifdef BTN_EVENT_RELEASE_EN
    for (int unsigned i = 0; i < 4; i++) begin
      if (rel_pend[i] && !push) begin
        push        = 1'b1;
        push_rel    = 1'b1;
        push_colour = 2'(i);
        rel_clr[i]  = 1'b1;
      end
    end
`endif
  end

`ifdef BTN_EVENT_RELEASE_EN
  assign wr_word     = {push_rel, push_colour};
  assign head_rel    = mem[rd_ptr][2];
`else
  assign wr_word     = push_colour;
  assign head_rel    = 1'b0;
`endif
  assign head_colour = mem[rd_ptr][1:0];

  // Pending bits clear even when the push is dropped on a full queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_pend <= '0;
`ifdef BTN_EVENT_RELEASE_EN
      rel_pend   <= '0;
`endif
    end else begin
      press_pend <= (press_pend & ~press_clr) | press_rise;
`ifdef BTN_EVENT_RELEASE_EN
      rel_pend   <= (rel_pend & ~rel_clr) | release_fall;
`endif
    end
  end

  assign rd_rise = rd_en & ~rd_en_q;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop     = rd_rise & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_en_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_en_q <= rd_en;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_rise) begin
        overflow <= drop;
        if (!empty) rd_data <= {overflow, 27'b0, head_rel, head_colour, 1'b1};
        else        rd_data <= {overflow, 31'b0};
      end else begin
        overflow <= overflow | drop;
      end
    end
  end

endmodule
